// File: rtl/alu_mc.sv
// ============================================================================
//  Module   : alu_mc
//  Brief    : Multi-cycle ALU with valid/ready handshake and registered flags.
//             The shift-add multiplier is built only with ALU_MC_MUL_EN defined.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [3:0]       OPCODE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    input  logic             OE,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic             CF,
    output logic             ZF,
    output logic             SF,
    output logic             OF
);

    localparam logic [3:0] c_OP_SUM = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0011;
    localparam logic [3:0] c_OP_AND = 4'b0100;
    localparam logic [3:0] c_OP_OR  = 4'b0101;
    localparam logic [3:0] c_OP_XOR = 4'b0110;
    localparam logic [3:0] c_OP_NOT = 4'b0111;
    localparam logic [3:0] c_OP_SHL = 4'b1000;
    localparam logic [3:0] c_OP_SHR = 4'b1001;
`ifdef ALU_MC_MUL_EN
    localparam logic [3:0] c_OP_MUL = 4'b1010;
`endif
    localparam logic [WIDTH-1:0] c_WIDTH_V = WIDTH'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_cf;
    logic             r_zf;
    logic             r_sf;
    logic             r_of;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic             w_big_shift;
    logic [WIDTH-1:0] w_res;
    logic             w_cf;
    logic             w_of;
    logic             w_mul_start;

    assign w_sum       = {1'b0, A} + {1'b0, B};
    // Bit WIDTH of the extended difference is the borrow, i.e. A < B.
    assign w_diff      = {1'b0, A} - {1'b0, B};
    assign w_shl       = {1'b0, A} << B;
    assign w_shr       = {A, 1'b0} >> B;
    assign w_big_shift = (B >= c_WIDTH_V);

    always_comb begin
        w_res       = '0;
        w_cf        = 1'b0;
        w_of        = 1'b0;
        w_mul_start = 1'b0;
        case (OPCODE)
            c_OP_SUM: begin
                w_res = w_sum[WIDTH-1:0];
                w_cf  = w_sum[WIDTH];
                w_of  = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_cf  = w_diff[WIDTH];
                w_of  = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            c_OP_AND: w_res = A & B;
            c_OP_OR:  w_res = A | B;
            c_OP_XOR: w_res = A ^ B;
            c_OP_NOT: w_res = ~A;
            // The extra bit beside the shifted operand catches the last bit shifted out.
            c_OP_SHL: begin
                if (!w_big_shift) begin
                    w_res = w_shl[WIDTH-1:0];
                    w_cf  = w_shl[WIDTH];
                end
            end
            c_OP_SHR: begin
                if (!w_big_shift) begin
                    w_res = w_shr[WIDTH:1];
                    w_cf  = w_shr[0];
                end
            end
`ifdef ALU_MC_MUL_EN
            c_OP_MUL: w_mul_start = 1'b1;
`endif
            default: ;
        endcase
    end

`ifdef ALU_MC_MUL_EN
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] w_prod_next;
    logic [WIDTH-1:0]   w_prod_lo;
    logic [WIDTH-1:0]   w_prod_hi;

    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_prod_lo   = w_prod_next[WIDTH-1:0];
    assign w_prod_hi   = w_prod_next[2*WIDTH-1:WIDTH];
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_cf        <= 1'b0;
            r_zf        <= 1'b1;
            r_sf        <= 1'b0;
            r_of        <= 1'b0;
`ifdef ALU_MC_MUL_EN
            r_mcand     <= '0;
            r_prod      <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (IN_VALID) begin
                        r_in_ready <= 1'b0;
`ifdef ALU_MC_MUL_EN
                        if (w_mul_start) begin
                            r_state  <= S_BUSY;
                            r_mcand  <= {{WIDTH{1'b0}}, A};
                            r_mplier <= B;
                            r_prod   <= '0;
                            r_cnt    <= '0;
                        end else
`endif
                        begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_res;
                            r_cf        <= w_cf;
                            r_of        <= w_of;
                            r_zf        <= (w_res == '0);
                            r_sf        <= w_res[WIDTH-1];
                        end
                    end
                end
`ifdef ALU_MC_MUL_EN
                S_BUSY: begin
                    r_prod   <= w_prod_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    // Final partial product is folded in on the same edge that enters DONE.
                    if (r_cnt == c_CNT_LAST) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_prod_lo;
                        r_cf        <= |w_prod_hi;
                        r_of        <= |w_prod_hi;
                        r_zf        <= (w_prod_lo == '0);
                        r_sf        <= w_prod_lo[WIDTH-1];
                    end
                end
`endif
                S_DONE: begin
                    if (OUT_READY) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign IN_READY  = r_in_ready;
    assign OUT_VALID = r_out_valid;
    assign ALU_OUT   = OE ? r_result : {WIDTH{1'bz}};
    assign CF        = r_cf;
    assign ZF        = r_zf;
    assign SF        = r_sf;
    assign OF        = r_of;

endmodule

`default_nettype wire

// File: tb/tb_alu_mc.sv
// ============================================================================
//  Module   : tb_alu_mc
//  Brief    : Scoreboard bench for alu_mc; expected results are queued by the
//             driver and checked by an independent output monitor.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_mc;

    localparam int WIDTH = 8;

    typedef struct {
        logic [7:0] res;
        logic       cf;
        logic       zf;
        logic       sf;
        logic       of;
        int         lat;
        int         acc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic       oe;
    wire  [7:0] alu_out;
    logic       cf;
    logic       zf;
    logic       sf;
    logic       of;

    int   n_cmp;
    int   n_err;
    int   cyc;
    exp_t q[$];

    alu_mc #(.WIDTH(WIDTH)) dut (
        .CLK       (clk),
        .RST       (rst),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .OPCODE    (opcode),
        .A         (a),
        .B         (b),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OE        (oe),
        .ALU_OUT   (alu_out),
        .CF        (cf),
        .ZF        (zf),
        .SF        (sf),
        .OF        (of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] res, input logic c, input logic z,
                                input logic s, input logic o, input int lat);
        exp_t e;
        e.res = res; e.cf = c; e.zf = z; e.sf = s; e.of = o; e.lat = lat; e.acc = 0;
        return e;
    endfunction

    // Called shortly after a rising edge; returns 2 time units after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb, input exp_t e);
        int   n;
        exp_t ee;
        ee = e;
        in_valid = 1'b1; opcode = op; a = va; b = vb;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 60) begin
                check("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        ee.acc = cyc;
        q.push_back(ee);
        #1;
        in_valid = 1'b0;
        opcode   = 4'($urandom);
        a        = 8'($urandom);
        b        = 8'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", q.size(), 32'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_in_ready"},  in_ready,  1'b1);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_result"},    alu_out,   8'h00);
        check({tag, "_zf"},        zf,        1'b1);
        check({tag, "_cf_sf_of"},  {cf, sf, of}, 3'b000);
    endtask

    // Output monitor: checks every DONE cycle against the queue head, pops on handshake.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = q[0];
                    if (!prev_valid) check("latency", cyc - e.acc + 1, e.lat);
                    check("result", alu_out, e.res);
                    check("flags_cf_zf_sf_of", {cf, zf, sf, of}, {e.cf, e.zf, e.sf, e.of});
                    if (out_ready) void'(q.pop_front());
                end
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; oe = 1'b1; out_ready = 1'b1;
        // Offer an operation during reset: reset must win.
        in_valid = 1'b1; opcode = 4'b0010; a = 8'h01; b = 8'h01;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0; in_valid = 1'b0;
        check_reset_state("reset");
        @(posedge clk);
        #2;

        issue(4'b0010, 8'h7F, 8'h01, mk(8'h80, 0, 0, 1, 1, 1));   // SUM signed overflow
        issue(4'b0011, 8'h05, 8'h07, mk(8'hFE, 1, 0, 1, 0, 1));   // SUB borrow
        issue(4'b0010, 8'hFF, 8'h01, mk(8'h00, 1, 1, 0, 0, 1));   // SUM carry, zero
        issue(4'b0011, 8'h80, 8'h01, mk(8'h7F, 0, 0, 0, 1, 1));   // SUB signed overflow
        issue(4'b0100, 8'hF0, 8'h3C, mk(8'h30, 0, 0, 0, 0, 1));   // AND
        issue(4'b0101, 8'h0F, 8'hF0, mk(8'hFF, 0, 0, 1, 0, 1));   // OR
        issue(4'b0110, 8'hAA, 8'hAA, mk(8'h00, 0, 1, 0, 0, 1));   // XOR
        issue(4'b0111, 8'h0F, 8'h00, mk(8'hF0, 0, 0, 1, 0, 1));   // NOT A
        issue(4'b1001, 8'h81, 8'h01, mk(8'h40, 1, 0, 0, 0, 1));   // SHR
        issue(4'b1000, 8'h81, 8'h00, mk(8'h81, 0, 0, 1, 0, 1));   // SHL by 0
        issue(4'b1000, 8'h01, 8'h07, mk(8'h80, 0, 0, 1, 0, 1));   // SHL by WIDTH-1
        issue(4'b1001, 8'hF0, 8'h08, mk(8'h00, 0, 1, 0, 0, 1));   // SHR by WIDTH
        issue(4'b1000, 8'hFF, 8'h09, mk(8'h00, 0, 1, 0, 0, 1));   // SHL beyond WIDTH
        issue(4'b1111, 8'h12, 8'h34, mk(8'h00, 0, 1, 0, 0, 1));   // undefined
        issue(4'b0000, 8'hFF, 8'hFF, mk(8'h00, 0, 1, 0, 0, 1));   // undefined
        drain();

        // Hold result in DONE while the consumer stalls and IN_VALID toggles.
        out_ready = 1'b0;
        issue(4'b1000, 8'h81, 8'h01, mk(8'h02, 1, 0, 0, 0, 1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_in_ready", in_ready, 1'b0);
            @(posedge clk);
            #2;
            in_valid = ~in_valid; opcode = 4'b0010; a = 8'h11; b = 8'h22;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

`ifdef ALU_MC_MUL_EN
        issue(4'b1010, 8'h10, 8'h11, mk(8'h10, 1, 0, 0, 1, 9));   // MUL with high bits
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("mul_in_ready", in_ready, 1'b0);
        end
        drain();
        issue(4'b1010, 8'h0F, 8'h03, mk(8'h2D, 0, 0, 0, 0, 9));   // MUL fits
        drain();

        // Abort a multiply in its 4th BUSY cycle.
        issue(4'b1010, 8'h10, 8'h11, mk(8'h10, 1, 0, 0, 1, 9));
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1; in_valid = 1'b1; opcode = 4'b0010;
        @(posedge clk);
        #2;
        rst = 1'b0; in_valid = 1'b0;
        q.delete();
        check_reset_state("abort_busy");
`else
        issue(4'b1010, 8'h03, 8'h04, mk(8'h00, 0, 1, 0, 0, 1));   // MUL absent
        drain();

        // Abort a result held in DONE.
        out_ready = 1'b0;
        issue(4'b0010, 8'h01, 8'h01, mk(8'h02, 0, 0, 0, 0, 1));
        @(posedge clk);
        #2;
        rst = 1'b1; in_valid = 1'b1; opcode = 4'b0010;
        @(posedge clk);
        #2;
        rst = 1'b0; in_valid = 1'b0;
        q.delete();
        out_ready = 1'b1;
        check_reset_state("abort_done");
`endif
        @(posedge clk);
        #2;
        issue(4'b0100, 8'hF0, 8'h3C, mk(8'h30, 0, 0, 0, 0, 1));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
